// File: rtl/gshare_predictor.sv
// Gshare branch predictor: PC^GHR indexed saturating counters with speculative history and mispredict repair.
// Optional performance counters are enabled by defining GSHARE_PERF_CNT_EN.
`timescale 1ns/1ps
module gshare_predictor #(
    parameter int HIST_BITS  = 8,
    parameter int CTR_BITS   = 2,
    parameter int INDEX_BITS = 8,
    parameter int PC_LSB     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  pred_valid,
    input  logic [31:0]           pred_pc,
    output logic                  pred_out_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    output logic [HIST_BITS-1:0]  pred_hist,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic [HIST_BITS-1:0]  upd_hist,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict
`ifdef GSHARE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_lookups,
    output logic [31:0]           perf_mispredicts
`endif
);

    localparam int DEPTH = 2 ** INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t                state;
    logic [INDEX_BITS-1:0] init_ptr;
    logic [HIST_BITS-1:0]  ghr;
    logic [CTR_BITS-1:0]   table_q [DEPTH];

    function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    // Drops the oldest bit; also covers HIST_BITS=1 where the result is just b.
    function automatic logic [HIST_BITS-1:0] shift_hist(input logic [HIST_BITS-1:0] h, input logic b);
        return HIST_BITS'({h, b});
    endfunction

    logic                  lkp_acc_p0;
    logic                  upd_acc_p0;
    logic [INDEX_BITS-1:0] lkp_idx_p0;
    logic                  rd_taken_p0;
    logic [CTR_BITS-1:0]   upd_ctr_p0;
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_addr;
    logic [CTR_BITS-1:0]   wr_data;
    logic                  pc_unused;

    assign pc_unused   = ^pred_pc;
    assign lkp_acc_p0  = (state == READY) && pred_valid;
    assign upd_acc_p0  = (state == READY) && upd_valid;
    assign lkp_idx_p0  = pred_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(ghr);
    assign rd_taken_p0 = table_q[lkp_idx_p0][CTR_BITS-1];
    assign upd_ctr_p0  = table_q[upd_index];

    // Single write port shared by init sweep and training; they never overlap.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = upd_index;
        wr_data = upd_taken ? sat_inc(upd_ctr_p0) : sat_dec(upd_ctr_p0);
        if (!reset) begin
            if (state == INIT) begin
                wr_en   = 1'b1;
                wr_addr = init_ptr;
                wr_data = CTR_INIT;
            end else begin
                wr_en = upd_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    // p0 -> p1: registered prediction and GHR maintenance
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= INIT;
            init_ptr       <= '0;
            ghr            <= '0;
            ready          <= 1'b0;
            pred_out_valid <= 1'b0;
            pred_taken     <= 1'b0;
            pred_index     <= '0;
            pred_hist      <= '0;
        end else begin
            pred_out_valid <= lkp_acc_p0;
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == '1) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                READY: begin
                    if (lkp_acc_p0) begin
                        pred_taken <= rd_taken_p0;
                        pred_index <= lkp_idx_p0;
                        pred_hist  <= ghr;
                    end
                    // Recovery overrides the speculative shift of a same-cycle lookup.
                    if (upd_acc_p0 && upd_mispredict) begin
                        ghr <= shift_hist(upd_hist, upd_taken);
                    end else if (lkp_acc_p0) begin
                        ghr <= shift_hist(ghr, rd_taken_p0);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef GSHARE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lookups     <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (lkp_acc_p0) begin
                perf_lookups <= perf_lookups + 32'd1;
            end
            if (upd_acc_p0 && upd_mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: lookups push expected responses, a monitor pops on pred_out_valid.
`timescale 1ns/1ps
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_out_valid;
    logic        pred_taken;
    logic [7:0]  pred_index;
    logic [7:0]  pred_hist;
    logic        upd_valid;
    logic [7:0]  upd_index;
    logic [7:0]  upd_hist;
    logic        upd_taken;
    logic        upd_mispredict;
`ifdef GSHARE_PERF_CNT_EN
    logic [31:0] perf_lookups;
    logic [31:0] perf_mispredicts;
`endif

    gshare_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .ready          (ready),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_out_valid (pred_out_valid),
        .pred_taken     (pred_taken),
        .pred_index     (pred_index),
        .pred_hist      (pred_hist),
        .upd_valid      (upd_valid),
        .upd_index      (upd_index),
        .upd_hist       (upd_hist),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict)
`ifdef GSHARE_PERF_CNT_EN
        ,
        .perf_lookups     (perf_lookups),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       taken;
        logic [7:0] idx;
        logic [7:0] hist;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pred_out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pred: got pred_out_valid=1 idx=0x%0h, want no output", pred_index);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pred_taken", {31'd0, pred_taken}, {31'd0, e.taken});
                chk("pred_index", {24'd0, pred_index}, {24'd0, e.idx});
                chk("pred_hist",  {24'd0, pred_hist},  {24'd0, e.hist});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic et, input logic [7:0] ei, input logic [7:0] eh);
        sb.push_back('{taken: et, idx: ei, hist: eh});
        pred_valid = 1'b1;
        pred_pc    = pc;
        cyc();
    endtask

    task automatic upd(input logic [7:0] idx, input logic tk, input logic mis, input logic [7:0] h);
        upd_valid      = 1'b1;
        upd_index      = idx;
        upd_taken      = tk;
        upd_mispredict = mis;
        upd_hist       = h;
        cyc();
    endtask

    // Forces the GHR through a mispredict at a scratch entry never looked up.
    task automatic set_ghr(input logic [7:0] h);
        upd(8'hF0, h[0], 1'b1, h >> 1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 400) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_index = '0; upd_hist = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",      {31'd0, ready},          32'd0);
        chk("rst_out_valid",  {31'd0, pred_out_valid}, 32'd0);
        chk("rst_pred_taken", {31'd0, pred_taken},     32'd0);
        chk("rst_pred_index", {24'd0, pred_index},     32'd0);
        chk("rst_pred_hist",  {24'd0, pred_hist},      32'd0);
`ifdef GSHARE_PERF_CNT_EN
        chk("rst_perf_lkp", perf_lookups,     32'd0);
        chk("rst_perf_mis", perf_mispredicts, 32'd0);
`endif
        reset = 1'b0;
        // A lookup during init must produce no output.
        pred_valid = 1'b1;
        pred_pc    = 32'h100;
        wait_ready(n);
        chk("init_cycles", n, 32'd256);

        // Reset and first lookup
        lookup(32'h100, 1'b0, 8'h40, 8'h00);

        // Training and increment saturation
        upd(8'h40, 1'b1, 1'b0, 8'h00);
        upd(8'h40, 1'b1, 1'b0, 8'h00);
        lookup(32'h100, 1'b1, 8'h40, 8'h00);
        upd(8'h40, 1'b1, 1'b0, 8'h00);
        upd(8'h40, 1'b0, 1'b0, 8'h00);
        set_ghr(8'h00);
        lookup(32'h100, 1'b1, 8'h40, 8'h00);
        upd(8'h40, 1'b0, 1'b0, 8'h00);
        set_ghr(8'h00);
        lookup(32'h100, 1'b0, 8'h40, 8'h00);

        // Decrement saturation
        repeat (4) upd(8'h40, 1'b0, 1'b0, 8'h00);
        lookup(32'h100, 1'b0, 8'h40, 8'h00);
        upd(8'h40, 1'b1, 1'b0, 8'h00);
        lookup(32'h100, 1'b0, 8'h40, 8'h00);

        // Mispredict recovery
        upd(8'hF0, 1'b1, 1'b1, 8'h05);
        lookup(32'h100, 1'b0, 8'h4B, 8'h0B);

        // Simultaneous lookup and mispredict: recovery wins the GHR
        set_ghr(8'h00);
        upd(8'h40, 1'b1, 1'b0, 8'h00);
        upd(8'h40, 1'b1, 1'b0, 8'h00);
        sb.push_back('{taken: 1'b1, idx: 8'h40, hist: 8'h00});
        pred_valid = 1'b1; pred_pc = 32'h100;
        upd_valid = 1'b1; upd_index = 8'hF0; upd_taken = 1'b0; upd_mispredict = 1'b1; upd_hist = 8'h80;
        cyc();
        lookup(32'h100, 1'b1, 8'h40, 8'h00);

        // Same-cycle lookup and training of the same entry reads the old counter
        set_ghr(8'h00);
        upd(8'h40, 1'b0, 1'b0, 8'h00);
        sb.push_back('{taken: 1'b1, idx: 8'h40, hist: 8'h00});
        pred_valid = 1'b1; pred_pc = 32'h100;
        upd_valid = 1'b1; upd_index = 8'h40; upd_taken = 1'b0; upd_mispredict = 1'b0; upd_hist = 8'h00;
        cyc();
        lookup(32'h104, 1'b0, 8'h40, 8'h01);

        // Reset mid-run restarts init
        upd(8'h40, 1'b0, 1'b0, 8'h00);
        upd(8'h40, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        pred_valid = 1'b1; pred_pc = 32'h100;
        cyc();
        chk("midrst_ready",     {31'd0, ready},          32'd0);
        chk("midrst_out_valid", {31'd0, pred_out_valid}, 32'd0);
`ifdef GSHARE_PERF_CNT_EN
        chk("midrst_perf_lkp", perf_lookups,     32'd0);
        chk("midrst_perf_mis", perf_mispredicts, 32'd0);
`endif
        reset = 1'b0;
        wait_ready(n);
        chk("reinit_cycles", n, 32'd256);
        upd(8'h40, 1'b1, 1'b0, 8'h00);
        lookup(32'h100, 1'b1, 8'h40, 8'h00);

        // Perf counters: 10 lookups, 3 mispredicts since reset
        set_ghr(8'h00);
        for (int i = 0; i < 9; i++) begin
            lookup(32'h200 + 32'(4 * i), 1'b0, 8'h80 + 8'(i), 8'h00);
        end
        set_ghr(8'h00);
        set_ghr(8'h00);
`ifdef GSHARE_PERF_CNT_EN
        chk("perf_lookups",     perf_lookups,     32'd10);
        chk("perf_mispredicts", perf_mispredicts, 32'd3);
`endif

        repeat (3) cyc();
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
